// File: rtl/ace_rd_arbiter.sv
// Two-requester round-robin arbiter in front of one ACE read master port.
// One burst in flight at a time; the R channel is routed to the grantee and RACK follows rlast.
module ace_rd_arbiter #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              s_arvalid,
  output logic [1:0]              s_arready,
  input  logic [2*ADDR_WIDTH-1:0] s_araddr,
  input  logic [15:0]             s_arlen,
  input  logic [5:0]              s_arsize,
  input  logic [7:0]              s_arsnoop,
  output logic [1:0]              s_rvalid,
  input  logic [1:0]              s_rready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [3:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic [3:0]              m_arsnoop,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [3:0]              m_rresp,
  input  logic                    m_rlast,
  output logic                    m_rack
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;

  state_t                  state_q;
  logic                    prio_q;
  logic                    gnt_q;
  logic                    arvalid_q;
  logic                    rack_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [3:0]              snoop_q;

  logic                    win_d;
  logic                    accept;
  logic                    in_data;

  // A lone requester always wins; a tie goes to the priority pointer.
  always_comb begin
    win_d = s_arvalid[1];
    if (s_arvalid == 2'b11) begin
      win_d = prio_q;
    end
  end

  assign accept    = !rst && (state_q == IDLE) && (s_arvalid != 2'b00);
  assign s_arready = accept ? (win_d ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      gnt_q     <= 1'b0;
      arvalid_q <= 1'b0;
      rack_q    <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      snoop_q   <= '0;
    end else begin
      rack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            gnt_q     <= win_d;
            addr_q    <= win_d ? s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_araddr[ADDR_WIDTH-1:0];
            len_q     <= win_d ? s_arlen[15:8]   : s_arlen[7:0];
            size_q    <= win_d ? s_arsize[5:3]   : s_arsize[2:0];
            snoop_q   <= win_d ? s_arsnoop[7:4]  : s_arsnoop[3:0];
            arvalid_q <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (m_rvalid && m_rready && m_rlast) begin
            rack_q  <= 1'b1;
            state_q <= ACK;
          end
        end
        ACK: begin
          // The requester just served loses the next tie.
          prio_q  <= ~gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_arvalid = arvalid_q;
  assign m_arid    = {{(ID_WIDTH-1){1'b0}}, gnt_q};
  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arsize  = size_q;
  assign m_arburst = 2'b01;
  assign m_arsnoop = snoop_q;
  assign m_rack    = rack_q;

  // R is a pure pass-through to the grantee; beats outside DATA stay stalled at the master.
  assign in_data  = (state_q == DATA);
  assign m_rready = in_data && s_rready[gnt_q];
  assign s_rvalid = {in_data && m_rvalid && gnt_q, in_data && m_rvalid && !gnt_q};
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;

  always_ff @(posedge clk) begin
    if (!rst && in_data && m_rvalid) begin
      assert (m_rid == m_arid)
        else $error("m_rid %0h differs from issued id %0h", m_rid, m_arid);
    end
  end

endmodule

// File: tb/tb_ace_rd_arbiter.sv
// Bench for ace_rd_arbiter: directed scenarios plus randomized bursts, checked against
// a transaction-level round-robin model (winner rule, burst length, RACK timing).
module tb_ace_rd_arbiter;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      s_arvalid = '0;
  logic [1:0]      s_arready;
  logic [2*AW-1:0] s_araddr = '0;
  logic [15:0]     s_arlen = '0;
  logic [5:0]      s_arsize = '0;
  logic [7:0]      s_arsnoop = '0;
  logic [1:0]      s_rvalid;
  logic [1:0]      s_rready = '0;
  logic [DW-1:0]   s_rdata;
  logic [3:0]      s_rresp;
  logic            s_rlast;
  logic            m_arvalid;
  logic            m_arready = 1'b0;
  logic [IW-1:0]   m_arid;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic [3:0]      m_arsnoop;
  logic            m_rvalid = 1'b0;
  logic            m_rready;
  logic [IW-1:0]   m_rid = '0;
  logic [DW-1:0]   m_rdata = '0;
  logic [3:0]      m_rresp = '0;
  logic            m_rlast = 1'b0;
  logic            m_rack;

  int errors = 0;
  int checks = 0;
  int prio_m = 0;

  logic [AW-1:0] ra [2];
  logic [7:0]    rl [2];
  logic [2:0]    rs [2];
  logic [3:0]    rn [2];

  ace_rd_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arsnoop(s_arsnoop), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arsnoop(m_arsnoop),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rack(m_rack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ar"}, {m_arvalid, m_araddr, m_arlen, m_arsize, m_arsnoop, m_arid}, '0);
    chk({tag, "_hs"}, {s_arready, s_rvalid, m_rready, m_rack}, '0);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] l,
                         input logic [2:0] sz, input logic [3:0] sn);
    ra[i] = a; rl[i] = l; rs[i] = sz; rn[i] = sn;
    s_araddr[i*AW +: AW] = a;
    s_arlen[i*8 +: 8]    = l;
    s_arsize[i*3 +: 3]   = sz;
    s_arsnoop[i*4 +: 4]  = sn;
  endtask

  // One full transaction starting in an idle cycle; returns the expected winner.
  task automatic burst(input logic [1:0] req, input bit hold, input int ar_stall,
                       input int rr_stall, input int abort_beat, output int w);
    int beats, got, guard, stall_left;
    bit stalled_once, xfer;
    s_arvalid = req;
    m_arready = 1'b0;
    m_rlast   = 1'b0;
    m_rvalid  = 1'($urandom_range(0, 1));
    #1;
    w = (req == 2'b11) ? prio_m : int'(req[1]);
    chk("accept_arready", s_arready, 2'b01 << w);
    chk("accept_quiet", {m_arvalid, m_rready, s_rvalid, m_rack}, '0);
    tick();
    if (!hold) s_arvalid[w] = 1'b0;

    for (int c = 0; c <= ar_stall; c++) begin
      m_arready = (c == ar_stall);
      m_rvalid  = 1'($urandom_range(0, 1));
      #1;
      chk("ar_fields", {m_arvalid, m_arburst, m_arid, m_araddr, m_arlen, m_arsize, m_arsnoop},
          {1'b1, 2'b01, IW'(w), ra[w], rl[w], rs[w], rn[w]});
      chk("ar_quiet", {s_arready, s_rvalid, m_rready, m_rack}, '0);
      tick();
    end
    m_arready = 1'b0;

    beats = int'(rl[w]) + 1;
    got = 0; guard = 0; stall_left = 0; stalled_once = 1'b0;
    m_rid = IW'(w);
    while (got < beats && guard < 400) begin
      guard++;
      if (rr_stall > 0 && got == 1 && !stalled_once) begin
        stall_left   = rr_stall;
        stalled_once = 1'b1;
      end
      s_rready = 2'($urandom_range(0, 3));
      m_rvalid = ($urandom_range(0, 3) != 0);
      if (stall_left > 0) begin
        s_rready[w] = 1'b0;
        m_rvalid    = 1'b1;
        stall_left--;
      end
      m_rdata = {$urandom, $urandom};
      m_rresp = 4'($urandom_range(0, 15));
      m_rlast = (got == beats - 1);
      #1;
      chk("r_valid_route", s_rvalid, m_rvalid ? (2'b01 << w) : 2'b00);
      chk("r_ready_route", m_rready, s_rready[w]);
      chk("r_payload", {s_rdata, s_rresp, s_rlast}, {m_rdata, m_rresp, m_rlast});
      chk("r_quiet", {m_arvalid, m_rack, s_arready}, '0);
      xfer = m_rvalid && s_rready[w];
      if (xfer) got++;
      tick();
      if (abort_beat > 0 && xfer && got == abort_beat) begin
        rst = 1'b1; m_rvalid = 1'b0; s_rready = '0;
        tick();
        rst = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b0; s_rready = 2'b11;
        #1;
        chk_reset_outputs("abort");
        prio_m = 0;
        for (int k = 0; k < 4; k++) begin
          chk("abort_no_rack", {m_rack, m_rready, s_rvalid}, '0);
          tick();
        end
        m_rvalid = 1'b0;
        s_rready = '0;
        return;
      end
    end
    chk("beats", got, beats);

    m_rvalid = 1'b1; m_rlast = 1'b0; s_rready = 2'b11;
    #1;
    chk("ack_rack", m_rack, 1'b1);
    chk("ack_quiet", {m_rready, s_rvalid, s_arready, m_arvalid}, '0);
    prio_m = 1 - w;
    tick();
    m_rvalid = 1'b0;
    s_rready = '0;
    #1;
    chk("rack_single", m_rack, 1'b0);
  endtask

  initial begin
    int w;
    logic [1:0] pend, req;

    rst = 1'b1; s_arvalid = 2'b11; m_rvalid = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("reset");
    s_arvalid = '0; m_rvalid = 1'b0; rst = 1'b0;
    tick();

    set_req(0, 32'h0000_1000, 8'd3, 3'd3, 4'd0);
    burst(2'b01, 1'b0, 0, 0, 0, w);

    set_req(0, 32'h0000_2000, 8'd1, 3'd3, 4'd1);
    burst(2'b01, 1'b0, 5, 0, 0, w);

    set_req(1, 32'h0000_3000, 8'd3, 3'd3, 4'd2);
    burst(2'b10, 1'b0, 0, 3, 0, w);

    set_req(0, 32'h0000_4000, 8'd1, 3'd2, 4'd3);
    set_req(1, 32'h0000_5000, 8'd2, 3'd3, 4'd4);
    for (int i = 0; i < 4; i++) burst(2'b11, 1'b1, 0, 0, 0, w);
    s_arvalid = '0;
    tick();

    for (int i = 0; i < 3; i++) begin
      m_rvalid = 1'b1; s_rready = 2'b11;
      #1;
      chk("stray_r", {m_rready, s_rvalid, s_arready, m_arvalid, m_rack}, '0);
      tick();
    end
    m_rvalid = 1'b0; s_rready = '0;

    set_req(0, 32'h0000_6000, 8'd0, 3'd3, 4'd0);
    burst(2'b01, 1'b0, 0, 0, 0, w);
    set_req(1, 32'h0000_7000, 8'd3, 3'd3, 4'd1);
    burst(2'b10, 1'b0, 0, 0, 2, w);
    set_req(0, 32'h0000_8000, 8'd1, 3'd3, 4'd2);
    set_req(1, 32'h0000_9000, 8'd1, 3'd3, 4'd3);
    burst(2'b11, 1'b0, 0, 0, 0, w);

    for (int i = 0; i < 12; i++) begin
      pend = s_arvalid;
      req  = pend | 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        if (req[r] && !pend[r])
          set_req(r, $urandom, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)));
      end
      burst(req, 1'b0, $urandom_range(0, 3), $urandom_range(0, 2), 0, w);
    end
    s_arvalid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ace_rd_arbiter.md
Name: ace_rd_arbiter

Overview:
- Shares one ACE read-address/read-data channel pair (AR/R plus RACK) between two cache-side requesters, e.g. I-fetch refill (port 0) and LSU refill (port 1).
- Round-robin arbitration with exactly one outstanding transaction at a time; each burst is locked to its grantee until rlast.
- Issues the ACE RACK handshake after each completed burst.
- Sits between the requesters and the core's ACE master port.

Parameters:
- ID_WIDTH, 4, width of m_arid / m_rid.
- ADDR_WIDTH, 32, AR address width.
- DATA_WIDTH, 64, R data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_arvalid  in  2  per-requester request valid; bit i = requester i
- s_arready  out  2  per-requester request accepted
- s_araddr  in  2*ADDR_WIDTH  request address; slice i = requester i
- s_arlen  in  2*8  burst length minus one
- s_arsize  in  2*3  beat size
- s_arsnoop  in  2*4  ACE ARSNOOP
- s_rvalid  out  2  data beat valid to requester i
- s_rready  in  2  requester i accepts beat
- s_rdata  out  DATA_WIDTH  shared data bus; meaningful only where s_rvalid is set
- s_rresp  out  4  shared ACE RRESP
- s_rlast  out  1  shared last-beat flag
- m_arvalid  out  1  master AR valid
- m_arready  in  1  master AR ready
- m_arid  out  ID_WIDTH  master AR ID
- m_araddr  out  ADDR_WIDTH  master AR address
- m_arlen  out  8  master AR length
- m_arsize  out  3  master AR size
- m_arburst  out  2  master AR burst type
- m_arsnoop  out  4  master ARSNOOP
- m_rvalid  in  1  master R valid
- m_rready  out  1  master R ready
- m_rid  in  ID_WIDTH  master R ID
- m_rdata  in  DATA_WIDTH  master R data
- m_rresp  in  4  master R response
- m_rlast  in  1  master R last beat
- m_rack  out  1  ACE read acknowledge

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset state:
  - FSM state = IDLE; priority pointer prio = 0; grant register gnt = 0.
  - All registered AR fields = 0.
  - m_arvalid = 0, m_rack = 0, s_arready = 0, s_rvalid = 0, m_rready = 0.
  - Reset asserted mid-transaction abandons the transaction; no RACK is issued for it.
- FSM states: IDLE, ADDR, DATA, ACK.
- IDLE:
  - Winner selection: if only one s_arvalid bit is set, that requester wins. If both are set, requester prio wins.
  - In the same cycle, s_arready[winner] = 1 (combinational, single-cycle pulse).
  - The winner's addr/len/size/snoop are captured, gnt <= winner, next state ADDR.
  - If no s_arvalid bit is set, stay in IDLE.
  - s_arready is never asserted outside IDLE.
- ADDR:
  - m_arvalid = 1, driven from registers.
  - m_arid = gnt zero-extended to ID_WIDTH.
  - m_arburst = 2'b01 (INCR); m_arlen, m_arsize, m_arsnoop come from the captured request.
  - Fields are held stable until m_arready.
  - On m_arvalid & m_arready, next state DATA.
- DATA:
  - Pass-through: s_rvalid[gnt] = m_rvalid, and m_rready = s_rready[gnt].
  - The other requester's s_rvalid bit stays 0.
  - s_rdata, s_rresp and s_rlast are m_rdata, m_rresp and m_rlast, combinational with zero added latency.
  - A beat transfers on m_rvalid & m_rready.
  - A beat carrying m_rlast moves the FSM to ACK.
  - Backpressure from the grantee stalls the master; there is no internal buffering.
- ACK:
  - m_rack = 1 for exactly one cycle.
  - prio <= ~gnt, so the just-served requester loses the next tie.
  - Next state IDLE.
  - A new request can therefore be accepted one cycle after ACK.
- m_rready outside DATA = 0. Any master R beat arriving outside DATA is stalled, not dropped.
- m_rid must equal the issued ID during DATA. A simulation assertion fires on mismatch; RTL ignores m_rid.
- Minimum transaction latency, for a single-beat read with m_arready=1 and m_rvalid available immediately:
  - s_arready at cycle N.
  - AR handshake at N+1.
  - R beat at N+2.
  - m_rack at N+3.
  - Next accept possible at N+4.
- Requester obligation: s_arvalid is not dropped before s_arready. Withdrawing early is a protocol violation and is not checked.

Test Plan:
- Single request: reset, then s_arvalid=2'b01, araddr0=0x1000, arlen0=3. Required: s_arready=2'b01 at the first cycle, m_arvalid next cycle with m_arid=0, m_araddr=0x1000, m_arlen=3, m_arburst=1. Four R beats go to s_rvalid[0] only, s_rlast on beat 4, m_rack one cycle later.
- Tie then alternation: s_arvalid=2'b11 held continuously. Required grant order 0,1,0,1; m_arid sequence 0,1,0,1; exactly one m_rack per burst.
- AR backpressure: m_arready=0 for 5 cycles. Required: m_arvalid stays 1 with m_araddr and m_arlen constant, no second s_arready, then state advances on the handshake.
- R backpressure: grantee 1 holds s_rready=0 for 3 cycles mid-burst. Required: m_rready=0 during those cycles, no beats lost, s_rvalid[0]=0 throughout.
- Reset mid-DATA: assert rst after beat 2 of 4. Required: next cycle all outputs are at reset values, m_rack never pulses for the aborted burst, and a new request afterwards is accepted with prio=0.
- Stray R: m_rvalid=1 while in IDLE. Required: m_rready=0 and no s_rvalid asserted.
